wb_stage: RTL and testbench

- Writeback stage directly downstream of the EX-stage control unit and ALU in the 3-stage MIPS core.
- Owns the HI/LO registers and the GPIO output latch.
- Registers the EX result into a WB pipeline register and drives the register-file write port.
- Keeps a retired-instruction counter.

---
 rtl/core_pkg.sv | 14 +
 rtl/wb_stage_if.sv | 36 +++
 rtl/hilo_regs.sv | 26 ++
 rtl/wb_stage.sv | 70 +++++++
 tb/tb_wb_stage.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared datapath types and register-select encodings for the core
package core_pkg;

  localparam int CORE_DATA_W = 32;
  localparam int CORE_REG_AW = 5;

  typedef logic [CORE_DATA_W-1:0] word_t;
  typedef logic [CORE_REG_AW-1:0] regaddr_t;

  localparam logic [1:0] REGSEL_ALU = 2'b00;
  localparam logic [1:0] REGSEL_HI  = 2'b01;
  localparam logic [1:0] REGSEL_LO  = 2'b10;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - EX-to-WB handshake bundle and register-file write port
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);

  logic              flush_EX;
  logic              regwrite_EX;
  logic              enhilo_EX;
  logic [1:0]        regsel_EX;
  logic              rdrt_EX;
  logic              gpio_out_EX;
  logic              gpio_in_EX;
  logic [REG_AW-1:0] rd_EX;
  logic [REG_AW-1:0] rt_EX;
  logic [DATA_W-1:0] alu_lo_EX;
  logic [DATA_W-1:0] alu_hi_EX;

  logic              regwrite_WB;
  logic [REG_AW-1:0] writeaddr_WB;
  logic [DATA_W-1:0] writedata_WB;

  // master is the EX side (control unit + ALU); slave is the writeback stage
  modport master (
    output flush_EX, regwrite_EX, enhilo_EX, regsel_EX, rdrt_EX,
           gpio_out_EX, gpio_in_EX, rd_EX, rt_EX, alu_lo_EX, alu_hi_EX,
    input  regwrite_WB, writeaddr_WB, writedata_WB
  );

  modport slave (
    input  flush_EX, regwrite_EX, enhilo_EX, regsel_EX, rdrt_EX,
           gpio_out_EX, gpio_in_EX, rd_EX, rt_EX, alu_lo_EX, alu_hi_EX,
    output regwrite_WB, writeaddr_WB, writedata_WB
  );

endinterface

// File: rtl/hilo_regs.sv
// rtl/hilo_regs.sv - HI/LO product register pair with a shared load enable
module hilo_regs
  import core_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] hi_d,
  input  logic [DATA_W-1:0] lo_d,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (load) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: WB pipeline register, HI/LO, GPIO latch, retire counter
module wb_stage
  import core_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int REG_AW = CORE_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  wb_stage_if.slave         bus,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic              live;
  logic [REG_AW-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign live  = ~bus.flush_EX;
  assign waddr = bus.rdrt_EX ? bus.rt_EX : bus.rd_EX;

  // HI/LO are read before the edge, so mfhi/mflo see the pre-update value
  always_comb begin
    wdata = bus.alu_lo_EX;
    if (bus.regsel_EX == REGSEL_HI) begin
      wdata = hi_o;
    end else if (bus.regsel_EX == REGSEL_LO) begin
      wdata = lo_o;
    end else if (bus.gpio_in_EX) begin
      wdata = gpio_in;
    end
  end

  hilo_regs #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .load (live & bus.enhilo_EX),
    .hi_d (bus.alu_hi_EX),
    .lo_d (bus.alu_lo_EX),
    .hi_q (hi_o),
    .lo_q (lo_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.regwrite_WB  <= 1'b0;
      bus.writeaddr_WB <= '0;
      bus.writedata_WB <= '0;
      gpio_out         <= '0;
      retired_cnt      <= '0;
    end else begin
      bus.regwrite_WB <= live & bus.regwrite_EX & (|waddr);
      if (live) begin
        bus.writeaddr_WB <= waddr;
        bus.writedata_WB <= wdata;
        retired_cnt      <= retired_cnt + 1'b1;
        if (bus.gpio_out_EX) begin
          gpio_out <= bus.alu_lo_EX;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed table-driven bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [3:0]  retired_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  wb_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  wb_stage #(
    .DATA_W (32),
    .REG_AW (5),
    .CNT_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        rw;
    logic        enhilo;
    logic [1:0]  regsel;
    logic        rdrt;
    logic        go;
    logic        gi;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [31:0] alu_lo;
    logic [31:0] alu_hi;
    logic [31:0] gpin;
    logic        e_rw;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic [31:0] e_go;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic flush, input logic rw, input logic enhilo,
                       input logic [1:0] regsel, input logic rdrt, input logic go,
                       input logic gi, input logic [4:0] rd, input logic [4:0] rt,
                       input logic [31:0] alu_lo, input logic [31:0] alu_hi,
                       input logic [31:0] gpin);
    bus.flush_EX    = flush;
    bus.regwrite_EX = rw;
    bus.enhilo_EX   = enhilo;
    bus.regsel_EX   = regsel;
    bus.rdrt_EX     = rdrt;
    bus.gpio_out_EX = go;
    bus.gpio_in_EX  = gi;
    bus.rd_EX       = rd;
    bus.rt_EX       = rt;
    bus.alu_lo_EX   = alu_lo;
    bus.alu_hi_EX   = alu_hi;
    gpio_in         = gpin;
  endtask

  task automatic check_all(input string tag, input logic e_rw, input logic [4:0] e_wa,
                           input logic [31:0] e_wd, input logic [31:0] e_hi,
                           input logic [31:0] e_lo, input logic [31:0] e_go,
                           input logic [3:0] e_cnt);
    chk({tag, " regwrite_WB"},  {31'd0, bus.regwrite_WB}, {31'd0, e_rw});
    chk({tag, " writeaddr_WB"}, {27'd0, bus.writeaddr_WB}, {27'd0, e_wa});
    chk({tag, " writedata_WB"}, bus.writedata_WB, e_wd);
    chk({tag, " hi_o"},         hi_o, e_hi);
    chk({tag, " lo_o"},         lo_o, e_lo);
    chk({tag, " gpio_out"},     gpio_out, e_go);
    chk({tag, " retired_cnt"},  {28'd0, retired_cnt}, {28'd0, e_cnt});
  endtask

  initial begin
    // flush rw hl sel rdrt go gi rd rt alu_lo alu_hi gpin | e_rw e_wa e_wd e_hi e_lo e_go e_cnt
    vecs[0]  = '{0,1,0,2'b00,0,0,0, 5,9,32'h0000_00AB,32'h0,32'h0,       1, 5,32'h0000_00AB,32'h1-1,32'h0,32'h0,4'd1};
    vecs[1]  = '{0,1,0,2'b00,1,0,0, 5,9,32'h0000_00AB,32'h0,32'h0,       1, 9,32'h0000_00AB,32'h0,32'h0,32'h0,4'd2};
    vecs[2]  = '{0,1,0,2'b00,0,0,0, 0,9,32'h0000_00CD,32'h0,32'h0,       0, 0,32'h0000_00CD,32'h0,32'h0,32'h0,4'd3};
    vecs[3]  = '{0,0,1,2'b00,0,0,0, 0,0,32'hFFFF_FFFE,32'h1,32'h0,       0, 0,32'hFFFF_FFFE,32'h1,32'hFFFF_FFFE,32'h0,4'd4};
    vecs[4]  = '{0,1,0,2'b01,0,0,0, 3,0,32'h0,32'h0,32'h0,               1, 3,32'h1,32'h1,32'hFFFF_FFFE,32'h0,4'd5};
    vecs[5]  = '{0,1,0,2'b10,0,0,0, 4,0,32'h0,32'h0,32'h0,               1, 4,32'hFFFF_FFFE,32'h1,32'hFFFF_FFFE,32'h0,4'd6};
    vecs[6]  = '{0,0,0,2'b00,0,1,0, 0,0,32'h5A5A,32'h0,32'h0,            0, 0,32'h5A5A,32'h1,32'hFFFF_FFFE,32'h5A5A,4'd7};
    vecs[7]  = '{0,1,0,2'b00,0,0,1, 7,0,32'h0,32'h0,32'h1234,            1, 7,32'h1234,32'h1,32'hFFFF_FFFE,32'h5A5A,4'd8};
    vecs[8]  = '{1,1,1,2'b00,0,1,0, 6,0,32'hDEAD,32'hBEEF,32'h0,         0, 7,32'h1234,32'h1,32'hFFFF_FFFE,32'h5A5A,4'd8};
    vecs[9]  = '{0,1,0,2'b11,0,0,0, 2,0,32'h77,32'h0,32'h0,              1, 2,32'h77,32'h1,32'hFFFF_FFFE,32'h5A5A,4'd9};
    vecs[10] = '{0,1,1,2'b01,0,0,0, 8,0,32'h22,32'h33,32'h0,             1, 8,32'h1,32'h33,32'h22,32'h5A5A,4'd10};
    vecs[11] = '{0,1,0,2'b10,0,0,1, 9,0,32'h0,32'h0,32'h999,             1, 9,32'h22,32'h33,32'h22,32'h5A5A,4'd11};
    vecs[12] = '{0,1,0,2'b00,0,1,0,10,0,32'hABCD,32'h0,32'h0,            1,10,32'hABCD,32'h33,32'h22,32'hABCD,4'd12};

    rst = 1'b1;
    drive(0,1,1,2'b00,0,1,0, 5,0,32'hFFFF,32'hFFFF,32'hFFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all("reset", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].flush, vecs[i].rw, vecs[i].enhilo, vecs[i].regsel, vecs[i].rdrt,
            vecs[i].go, vecs[i].gi, vecs[i].rd, vecs[i].rt, vecs[i].alu_lo,
            vecs[i].alu_hi, vecs[i].gpin);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_wa, vecs[i].e_wd,
                vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_go, vecs[i].e_cnt);
    end

    // three live ALU writes, then reset with a write still requested
    for (int i = 0; i < 3; i++) begin
      drive(0,1,0,2'b00,0,0,0, 5'(11 + i),0,32'(100 + i),32'h0,32'h0);
      @(posedge clk); #1;
    end
    check_all("pre_rst", 1, 13, 32'd102, 32'h33, 32'h22, 32'hABCD, 4'd15);
    rst = 1'b1;
    drive(0,1,1,2'b00,0,1,0, 5,0,32'h55,32'h66,32'h0);
    @(posedge clk); #1;
    check_all("mid_rst", 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0);
    rst = 1'b0;

    // counter wrap with CNT_W=4: 15 live edges reach 15, the 16th wraps to 0
    drive(0,0,0,2'b00,0,0,0, 0,0,32'h0,32'h0,32'h0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    chk("cnt_15", {28'd0, retired_cnt}, 32'd15);
    drive(1,0,0,2'b00,0,0,0, 0,0,32'h0,32'h0,32'h0);
    @(posedge clk); #1;
    chk("cnt_flush_hold", {28'd0, retired_cnt}, 32'd15);
    drive(0,0,0,2'b00,0,0,0, 0,0,32'h0,32'h0,32'h0);
    @(posedge clk); #1;
    chk("cnt_wrap", {28'd0, retired_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
